// File: rtl/choreo_pkg.sv
// Shared types and constants for the front-panel control stage.
// Pattern codes, debouncer state encoding and a modulo pattern-step helper.
package choreo_pkg;

  localparam int PAT_W   = 3;
  localparam int NUM_PAT = 8;

  typedef enum logic [PAT_W-1:0] {
    PAT_KNIGHT  = 3'd0,
    PAT_WALK    = 3'd1,
    PAT_EXPAND  = 3'd2,
    PAT_BLINK   = 3'd3,
    PAT_ALT     = 3'd4,
    PAT_MARQUEE = 3'd5,
    PAT_SPARKLE = 3'd6,
    PAT_OFF     = 3'd7
  } pat_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONF_P = 2'd1,
    HELD   = 2'd2,
    CONF_R = 2'd3
  } deb_state_e;

  // One step forward or back through the pattern list, wrapping at numPat.
  function automatic logic [PAT_W-1:0] patStep(input logic [PAT_W-1:0] cur,
                                               input logic up,
                                               input int numPat);
    logic [PAT_W-1:0] last;
    last = PAT_W'(numPat - 1);
    if (up) patStep = (cur == last) ? '0 : cur + PAT_W'(1);
    else    patStep = (cur == '0) ? last : cur - PAT_W'(1);
  endfunction

endpackage

// File: rtl/choreo_input_ctrl_debounce.sv
// Per-button 2-flop synchroniser plus confirm/held/release debouncer.
// Emits a registered one-cycle press pulse; releases never pulse.
module btn_debounce #(
  parameter int DEB_CNT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_raw,
  output logic o_press
);
  import choreo_pkg::*;

  localparam int CNT_W = $clog2(DEB_CNT + 1);

  logic             r_sync1;
  logic             r_sync2;
  deb_state_e       r_state;
  deb_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_press;
  logic             w_press_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
    end
  end

  // A bounce back to the old level during confirmation abandons the transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_sync2) begin
          w_state_nxt = CONF_P;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      CONF_P: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(DEB_CNT)) begin
          w_state_nxt = HELD;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!r_sync2) begin
          w_state_nxt = CONF_R;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      CONF_R: begin
        if (r_sync2) begin
          w_state_nxt = HELD;
        end else if (r_cnt == CNT_W'(DEB_CNT)) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_press = r_press;

endmodule

// File: rtl/choreo_input_ctrl.sv
// Front-panel control: four debounced buttons drive pat_sel/speed_sel/pause.
// Optional auto-advance timer is built only when AUTO_CYCLE_EN is defined.
module choreo_input_ctrl #(
  parameter int DEB_CNT  = 2,
  parameter int NUM_PAT  = 8,
  parameter int AUTO_PER = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        btn_next_raw,
  input  logic                        btn_prev_raw,
  input  logic                        btn_speed_raw,
  input  logic                        btn_pause_raw,
`ifdef AUTO_CYCLE_EN
  input  logic                        auto_en,
`endif
  output logic [choreo_pkg::PAT_W-1:0] pat_sel,
  output logic                        speed_sel,
  output logic                        pause,
  output logic                        pat_change
);
  import choreo_pkg::*;

  logic             w_next;
  logic             w_prev;
  logic             w_speed;
  logic             w_pause;
  logic             w_next_acc;
  logic             w_prev_acc;
  logic             w_auto_fire;
  logic [PAT_W-1:0] r_pat;
  logic             r_speed;
  logic             r_pause;
  logic             r_pat_change;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_next (
    .clk(clk), .rst_n(rst_n), .i_btn_raw(btn_next_raw), .o_press(w_next));
  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_prev (
    .clk(clk), .rst_n(rst_n), .i_btn_raw(btn_prev_raw), .o_press(w_prev));
  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_speed (
    .clk(clk), .rst_n(rst_n), .i_btn_raw(btn_speed_raw), .o_press(w_speed));
  btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_pause (
    .clk(clk), .rst_n(rst_n), .i_btn_raw(btn_pause_raw), .o_press(w_pause));

  // Opposing next/prev pulses in the same cycle cancel each other out.
  assign w_next_acc = ena & w_next & ~w_prev;
  assign w_prev_acc = ena & w_prev & ~w_next;

`ifdef AUTO_CYCLE_EN
  localparam int TMR_W = (AUTO_PER > 1) ? $clog2(AUTO_PER) : 1;

  logic             w_auto_run;
  logic [TMR_W-1:0] r_timer;

  assign w_auto_run  = auto_en & ena & ~r_pause;
  assign w_auto_fire = w_auto_run && (r_timer == TMR_W'(AUTO_PER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_timer <= '0;
    else if (!w_auto_run || w_next_acc || w_prev_acc || w_auto_fire)
      r_timer <= '0;
    else
      r_timer <= r_timer + TMR_W'(1);
  end
`else
  assign w_auto_fire = 1'b0;
`endif

  // Manual navigation takes priority over an auto-advance in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat        <= '0;
      r_speed      <= 1'b0;
      r_pause      <= 1'b0;
      r_pat_change <= 1'b0;
    end else begin
      r_pat_change <= 1'b0;
      if (w_next_acc) begin
        r_pat        <= patStep(r_pat, 1'b1, NUM_PAT);
        r_pat_change <= 1'b1;
      end else if (w_prev_acc) begin
        r_pat        <= patStep(r_pat, 1'b0, NUM_PAT);
        r_pat_change <= 1'b1;
      end else if (w_auto_fire) begin
        r_pat        <= patStep(r_pat, 1'b1, NUM_PAT);
        r_pat_change <= 1'b1;
      end
      if (ena && w_speed) r_speed <= ~r_speed;
      if (ena && w_pause) r_pause <= ~r_pause;
    end
  end

  assign pat_sel    = r_pat;
  assign speed_sel  = r_speed;
  assign pause      = r_pause;
  assign pat_change = r_pat_change;

endmodule

// File: tb/tb_choreo_input_ctrl.sv
// Directed self-checking bench for choreo_input_ctrl (DEB_CNT=2, NUM_PAT=8).
// Auto-advance steps are compiled in only when AUTO_CYCLE_EN is defined.
module tb_choreo_input_ctrl;
  import choreo_pkg::*;

  localparam logic [3:0] B_NEXT  = 4'b0001;
  localparam logic [3:0] B_PREV  = 4'b0010;
  localparam logic [3:0] B_SPEED = 4'b0100;
  localparam logic [3:0] B_PAUSE = 4'b1000;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic [3:0]       btnRaw;
  logic [PAT_W-1:0] pat_sel;
  logic             speed_sel;
  logic             pause;
  logic             pat_change;
`ifdef AUTO_CYCLE_EN
  logic             auto_en;
`endif

  int errors;
  int checks;
  int changeCount;
  int base;

  choreo_input_ctrl #(.DEB_CNT(2), .NUM_PAT(8), .AUTO_PER(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .btn_next_raw (btnRaw[0]),
    .btn_prev_raw (btnRaw[1]),
    .btn_speed_raw(btnRaw[2]),
    .btn_pause_raw(btnRaw[3]),
`ifdef AUTO_CYCLE_EN
    .auto_en      (auto_en),
`endif
    .pat_sel      (pat_sel),
    .speed_sel    (speed_sel),
    .pause        (pause),
    .pat_change   (pat_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pat_change pulses on the falling edge, away from the update edge.
  initial changeCount = 0;
  always @(negedge clk) if (pat_change === 1'b1) changeCount++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] bits, input int hold, input int idle);
    btnRaw = bits;
    tick(hold);
    btnRaw = 4'b0000;
    tick(idle);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    btnRaw = 4'b0000;
`ifdef AUTO_CYCLE_EN
    auto_en = 1'b0;
`endif
    tick(2);
    checkOutput("reset pat_sel", 32'(pat_sel), 32'd0);
    checkOutput("reset speed_sel", 32'(speed_sel), 32'd0);
    checkOutput("reset pause", 32'(pause), 32'd0);
    checkOutput("reset pat_change", 32'(pat_change), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] step 1: held next, latency and single press");
    base   = changeCount;
    btnRaw = B_NEXT;
    tick(5);
    checkOutput("latency edge4 pat_sel", 32'(pat_sel), 32'd0);
    tick(1);
    checkOutput("latency edge5 pat_sel", 32'(pat_sel), 32'd1);
    checkOutput("latency edge5 pat_change", 32'(pat_change), 32'd1);
    tick(1);
    checkOutput("pat_change one cycle", 32'(pat_change), 32'd0);
    tick(13);
    btnRaw = 4'b0000;
    tick(10);
    checkOutput("held next pat_sel", 32'(pat_sel), 32'd1);
    checkOutput("held next pulses", 32'(changeCount - base), 32'd1);

    $display("[TB] step 2: pause glitch rejection and toggling");
    applyStimulus(B_PAUSE, 2, 8);
    checkOutput("pause glitch", 32'(pause), 32'd0);
    applyStimulus(B_PAUSE, 4, 8);
    checkOutput("pause toggle on", 32'(pause), 32'd1);
    applyStimulus(B_PAUSE, 4, 8);
    checkOutput("pause toggle off", 32'(pause), 32'd0);

    $display("[TB] step 3: wrap-around");
    for (int i = 0; i < 6; i++) applyStimulus(B_NEXT, 6, 8);
    checkOutput("walk to last", 32'(pat_sel), 32'(PAT_OFF));
    base = changeCount;
    applyStimulus(B_NEXT, 6, 8);
    checkOutput("next wraps", 32'(pat_sel), 32'(PAT_KNIGHT));
    checkOutput("next wrap pulse", 32'(changeCount - base), 32'd1);
    base = changeCount;
    applyStimulus(B_PREV, 6, 8);
    checkOutput("prev wraps", 32'(pat_sel), 32'(PAT_OFF));
    checkOutput("prev wrap pulse", 32'(changeCount - base), 32'd1);

    $display("[TB] step 4: simultaneous next+prev");
    base = changeCount;
    applyStimulus(B_NEXT | B_PREV, 6, 8);
    checkOutput("next+prev pat_sel", 32'(pat_sel), 32'd7);
    checkOutput("next+prev pulses", 32'(changeCount - base), 32'd0);

    $display("[TB] step 5: presses ignored while disabled");
    ena  = 1'b0;
    base = changeCount;
    applyStimulus(B_SPEED | B_NEXT, 6, 8);
    checkOutput("disabled speed", 32'(speed_sel), 32'd0);
    checkOutput("disabled pat_sel", 32'(pat_sel), 32'd7);
    checkOutput("disabled pulses", 32'(changeCount - base), 32'd0);
    ena = 1'b1;
    tick(10);
    checkOutput("no queued speed", 32'(speed_sel), 32'd0);
    checkOutput("no queued pat_sel", 32'(pat_sel), 32'd7);

    $display("[TB] step 6: independent presses and navigation while paused");
    applyStimulus(B_SPEED | B_PAUSE, 6, 8);
    checkOutput("combo speed", 32'(speed_sel), 32'd1);
    checkOutput("combo pause", 32'(pause), 32'd1);
    applyStimulus(B_NEXT, 6, 8);
    checkOutput("next while paused", 32'(pat_sel), 32'd0);
    checkOutput("pause kept", 32'(pause), 32'd1);

    $display("[TB] step 7: reset mid-press");
    btnRaw = B_NEXT;
    tick(3);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset pat_sel", 32'(pat_sel), 32'd0);
    checkOutput("async reset speed", 32'(speed_sel), 32'd0);
    checkOutput("async reset pause", 32'(pause), 32'd0);
    #2;
    rst_n = 1'b1;
    tick(12);
    checkOutput("press after reset", 32'(pat_sel), 32'd1);
    btnRaw = 4'b0000;
    tick(10);
    checkOutput("single press after reset", 32'(pat_sel), 32'd1);

`ifdef AUTO_CYCLE_EN
    $display("[TB] step 8: auto-advance");
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    auto_en = 1'b1;
    tick(31);
    checkOutput("auto before expiry", 32'(pat_sel), 32'd0);
    tick(1);
    checkOutput("auto first advance", 32'(pat_sel), 32'd1);
    checkOutput("auto pat_change", 32'(pat_change), 32'd1);
    tick(31);
    checkOutput("auto before second", 32'(pat_sel), 32'd1);
    tick(1);
    checkOutput("auto second advance", 32'(pat_sel), 32'd2);
    applyStimulus(B_PAUSE, 6, 40);
    checkOutput("auto paused pause", 32'(pause), 32'd1);
    checkOutput("auto paused hold", 32'(pat_sel), 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("auto reset pat_sel", 32'(pat_sel), 32'd0);
    checkOutput("auto reset pause", 32'(pause), 32'd0);
    checkOutput("auto reset pat_change", 32'(pat_change), 32'd0);
    auto_en = 1'b0;
    rst_n   = 1'b1;
    tick(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
